// File: rtl/mmio_matmul_accel.sv
// Memory-mapped NxN integer matrix multiplier: A/B/C register files, a single
// MAC engine walking (i, j, k) with k fastest, status/error reporting and an IRQ.
module mmio_matmul_accel #(
  parameter int N    = 4,
  parameter int DW   = 8,
  parameter int ACCW = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        irq
);
  localparam int NN = N * N;
  localparam int AW = $clog2(NN);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t            state_q;
  logic [DW-1:0]     a_q [NN];
  logic [DW-1:0]     b_q [NN];
  logic [ACCW-1:0]   c_q [NN];
  logic [ACCW-1:0]   acc_q, acc_d, prod;
  logic [31:0]       cycles_q, rdata_q, rd_val;
  logic [CW-1:0]     i_q, j_q, k_q;
  logic              irq_en_q, signed_q, sgn_run_q, done_q, err_q, ready_q;
  logic              busy, accept, idx_ok, mapped;
  logic              is_ctrl, is_stat, is_cyc, is_a, is_b, is_c;
  logic [3:0]        region;
  logic [5:0]        widx;
  logic [AW-1:0]     bus_idx, ai, bi, ci;

  // DW x DW product, sign- or zero-extended, wrapped into the accumulator width.
  function automatic logic [ACCW-1:0] mul_ext(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic sgn);
    logic signed [DW:0]     ea, eb;
    logic signed [2*DW+1:0] p;
    ea = sgn ? $signed({a[DW-1], a}) : $signed({1'b0, a});
    eb = sgn ? $signed({b[DW-1], b}) : $signed({1'b0, b});
    p  = ea * eb;
    return ACCW'(p);
  endfunction

  always_comb begin
    region  = mem_addr[11:8];
    widx    = mem_addr[7:2];
    bus_idx = AW'(widx);
    idx_ok  = {1'b0, widx} < 7'(NN);
    is_ctrl = (region == 4'h0) && (widx == 6'd0);
    is_stat = (region == 4'h0) && (widx == 6'd1);
    is_cyc  = (region == 4'h0) && (widx == 6'd2);
    is_a    = (region == 4'h1) && idx_ok;
    is_b    = (region == 4'h2) && idx_ok;
    is_c    = (region == 4'h3) && idx_ok;
    mapped  = is_ctrl | is_stat | is_cyc | is_a | is_b | is_c;
    busy    = (state_q != S_IDLE);
    accept  = mem_valid && !ready_q;

    rd_val = 32'hDEAD_BEEF;
    if (is_ctrl)      rd_val = {29'b0, signed_q, irq_en_q, 1'b0};
    else if (is_stat) rd_val = {29'b0, err_q, done_q, busy};
    else if (is_cyc)  rd_val = cycles_q;
    else if (is_a)    rd_val = 32'(a_q[bus_idx]);
    else if (is_b)    rd_val = 32'(b_q[bus_idx]);
    else if (is_c)    rd_val = 32'(c_q[bus_idx]);

    ai    = AW'(int'(i_q) * N + int'(k_q));
    bi    = AW'(int'(k_q) * N + int'(j_q));
    ci    = AW'(int'(i_q) * N + int'(j_q));
    prod  = mul_ext(a_q[ai], b_q[bi], sgn_run_q);
    acc_d = ((k_q == '0) ? '0 : acc_q) + prod;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      for (int n = 0; n < NN; n++) begin
        a_q[n] <= '0;
        b_q[n] <= '0;
        c_q[n] <= '0;
      end
      acc_q     <= '0;
      cycles_q  <= '0;
      rdata_q   <= '0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      irq_en_q  <= 1'b0;
      signed_q  <= 1'b0;
      sgn_run_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      ready_q <= accept;
      rdata_q <= (accept && !mem_write) ? rd_val : '0;

      if (accept && !mapped) begin
        err_q <= 1'b1;
      end else if (accept && mem_write && mem_wstrb[0]) begin
        if (is_ctrl) begin
          if (busy && mem_wdata[0]) begin
            err_q <= 1'b1;
          end else begin
            irq_en_q <= mem_wdata[1];
            signed_q <= mem_wdata[2];
            if (mem_wdata[0]) begin
              state_q   <= S_RUN;
              sgn_run_q <= mem_wdata[2];
              done_q    <= 1'b0;
              cycles_q  <= '0;
              i_q       <= '0;
              j_q       <= '0;
              k_q       <= '0;
            end
          end
        end else if (is_stat) begin
          if (mem_wdata[1]) done_q <= 1'b0;
          if (mem_wdata[2]) err_q  <= 1'b0;
        end else if (is_a || is_b) begin
          if (busy)      err_q          <= 1'b1;
          else if (is_a) a_q[bus_idx]   <= mem_wdata[DW-1:0];
          else           b_q[bus_idx]   <= mem_wdata[DW-1:0];
        end
      end

      // Engine: placed after the bus so a DONE set beats a same-cycle W1C.
      case (state_q)
        S_RUN: begin
          acc_q    <= acc_d;
          cycles_q <= cycles_q + 32'd1;
          if (k_q == CW'(N - 1)) begin
            c_q[ci] <= acc_d;
            k_q     <= '0;
            if (j_q == CW'(N - 1)) begin
              j_q <= '0;
              if (i_q == CW'(N - 1)) begin
                i_q     <= '0;
                state_q <= S_FIN;
              end else begin
                i_q <= i_q + 1'b1;
              end
            end else begin
              j_q <= j_q + 1'b1;
            end
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          done_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign irq       = irq_en_q & done_q;
endmodule

// File: tb/tb_mmio_matmul_accel.sv
// Directed bench for mmio_matmul_accel (N=4, DW=8): bus protocol, runs in
// signed/unsigned mode, busy and unmapped errors, IRQ and mid-run reset.
module tb_mmio_matmul_accel;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready, irq;

  int n_checks = 0;
  int n_errors = 0;
  int last_lat;
  logic last_after_rdy;
  logic [31:0] last_after_rdata;
  logic [31:0] rd;
  int cnt;

  mmio_matmul_accel #(.N(4), .DW(8), .ACCW(32)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One bus transaction; returns in the cycle after mem_ready.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, output logic [31:0] rdata);
    int n;
    mem_valid = 1'b1; mem_write = wr; mem_addr = addr; mem_wdata = wdata; mem_wstrb = strb;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!mem_ready && n < 10);
    if (!mem_ready) chk("ready_timeout", 32'd0, 32'd1);
    rdata = mem_rdata;
    last_lat = n;
    mem_valid = 1'b0; mem_write = 1'b0; mem_wstrb = 4'h0;
    @(posedge clk); #1;
    last_after_rdy   = mem_ready;
    last_after_rdata = mem_rdata;
  endtask

  task automatic wr32(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    xfer(1'b1, addr, data, 4'hF, dummy);
  endtask

  task automatic rd32(input logic [31:0] addr, output logic [31:0] data);
    xfer(1'b0, addr, 32'h0, 4'h0, data);
  endtask

  task automatic fill(input logic [31:0] base, input logic [7:0] val);
    for (int n = 0; n < 16; n++) wr32(base + 32'(4 * n), 32'(val));
  endtask

  task automatic wait_irq(inout int c);
    while (!irq && c < 300) begin
      @(posedge clk); #1; c++;
    end
  endtask

  task automatic check_all_c(input string tag, input logic [31:0] exp);
    logic [31:0] v;
    for (int n = 0; n < 16; n++) begin
      rd32(32'h300 + 32'(4 * n), v);
      chk(tag, v, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_valid = 1'b0; mem_write = 1'b0;
    mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;

    chk("rst_ready", 32'(mem_ready), 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rd32(32'h000, rd); chk("rst_ctrl", rd, 32'd0);
    rd32(32'h004, rd); chk("rst_status", rd, 32'd0);
    rd32(32'h008, rd); chk("rst_cycles", rd, 32'd0);
    rd32(32'h100, rd); chk("rst_a00", rd, 32'd0);
    rd32(32'h300, rd); chk("rst_c00", rd, 32'd0);

    // Identity x ramp, IRQ enabled so DONE is visible on irq.
    for (int n = 0; n < 16; n++) begin
      wr32(32'h100 + 32'(4 * n), (n / 4 == n % 4) ? 32'd1 : 32'd0);
      wr32(32'h200 + 32'(4 * n), 32'(n));
    end
    rd32(32'h114, rd); chk("a11_readback", rd, 32'd1);
    wr32(32'h000, 32'h3);
    cnt = 1;
    rd32(32'h004, rd); chk("busy_during_run", rd, 32'h1);
    cnt += 2;
    wait_irq(cnt);
    chk("done_latency", 32'(cnt), 32'd65);
    for (int n = 0; n < 16; n++) begin
      rd32(32'h300 + 32'(4 * n), rd);
      chk("c_identity", rd, 32'(n));
    end
    rd32(32'h008, rd); chk("cycles_64", rd, 32'd64);
    rd32(32'h004, rd); chk("status_done", rd, 32'h2);
    chk("irq_set", 32'(irq), 32'd1);
    wr32(32'h004, 32'h2);
    chk("irq_cleared", 32'(irq), 32'd0);

    // Signed -128 * -128.
    fill(32'h100, 8'h80); fill(32'h200, 8'h80);
    rd32(32'h100, rd); chk("a_zero_ext", rd, 32'h80);
    wr32(32'h000, 32'h7); cnt = 1; wait_irq(cnt);
    check_all_c("c_signed_m128", 32'h0001_0000);
    wr32(32'h000, 32'h3); cnt = 1; wait_irq(cnt);
    check_all_c("c_unsigned_128", 32'h0001_0000);

    // Signed -1 * 2 distinguishes sign handling.
    fill(32'h100, 8'hFF); fill(32'h200, 8'h02);
    wr32(32'h000, 32'h7); cnt = 1; wait_irq(cnt);
    check_all_c("c_signed_neg", 32'hFFFF_FFF8);
    rd32(32'h000, rd); chk("ctrl_readback", rd, 32'h6);

    // Unsigned 255 * 255.
    fill(32'h200, 8'hFF);
    wr32(32'h000, 32'h3); cnt = 1; wait_irq(cnt);
    check_all_c("c_unsigned_ff", 32'd260100);

    // Writes while busy are rejected with ERR.
    wr32(32'h000, 32'h3);
    wr32(32'h100, 32'h5);
    wr32(32'h000, 32'h1);
    rd32(32'h100, rd); chk("a00_busy_ignored", rd, 32'hFF);
    rd32(32'h004, rd); chk("status_busy_err", rd, 32'h5);
    cnt = 1; wait_irq(cnt);
    chk("irq_en_kept", 32'(irq), 32'd1);
    rd32(32'h300, rd); chk("c00_after_busy", rd, 32'd260100);
    rd32(32'h004, rd); chk("status_done_err", rd, 32'h6);
    wr32(32'h004, 32'h4);
    rd32(32'h004, rd); chk("err_w1c", rd, 32'h2);

    // Unmapped accesses, strobe gating, RO writes.
    rd32(32'h0FC, rd); chk("unmapped_0fc", rd, 32'hDEAD_BEEF);
    rd32(32'h004, rd); chk("unmapped_err", rd, 32'h6);
    wr32(32'h004, 32'h4);
    rd32(32'h140, rd); chk("unmapped_idx16", rd, 32'hDEAD_BEEF);
    wr32(32'h004, 32'h6);
    xfer(1'b1, 32'h100, 32'h33, 4'b0010, rd);
    chk("ready_latency", 32'(last_lat), 32'd1);
    chk("ready_single_pulse", 32'(last_after_rdy), 32'd0);
    chk("rdata_idle_zero", last_after_rdata, 32'd0);
    rd32(32'h100, rd); chk("a00_strobe_gated", rd, 32'hFF);
    wr32(32'h300, 32'h1234);
    rd32(32'h300, rd); chk("c00_ro", rd, 32'd260100);
    wr32(32'h008, 32'h55);
    rd32(32'h008, rd); chk("cycles_ro", rd, 32'd64);
    rd32(32'h004, rd); chk("ro_write_no_err", rd, 32'h0);
    chk("irq_low_after_w1c", 32'(irq), 32'd0);

    // Reset in the middle of a run.
    wr32(32'h000, 32'h3);
    repeat (20) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("midrst_irq", 32'(irq), 32'd0);
    chk("midrst_ready", 32'(mem_ready), 32'd0);
    rd32(32'h004, rd); chk("midrst_status", rd, 32'd0);
    rd32(32'h008, rd); chk("midrst_cycles", rd, 32'd0);
    rd32(32'h000, rd); chk("midrst_ctrl", rd, 32'd0);
    rd32(32'h100, rd); chk("midrst_a00", rd, 32'd0);
    rd32(32'h214, rd); chk("midrst_b11", rd, 32'd0);
    check_all_c("midrst_c", 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mmio_matmul_accel.md
Name: mmio_matmul_accel

Overview:
Parametrised NxN integer matrix-multiply accelerator behind a simple memory-mapped slave port. It is the generalised successor of the fixed 3x3 memory-mapped accelerator wrapper. It holds A, B and C register files and a sequential single-MAC engine computing C = A x B. It adds status/error reporting, signed/unsigned mode, a cycle counter and an interrupt output. A CPU or testbench master uses it as a self-contained slave.

Parameters:
N, 4, matrix dimension (2..8)
DW, 8, element width of A and B
ACCW, 32, accumulator / C element width (fixed 32 for bus reads; values wrap modulo 2^32)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_valid  in  1  transaction request, held until mem_ready
mem_write  in  1  1 = write, 0 = read
mem_addr  in  32  byte address; only [11:0] decoded
mem_wdata  in  32  write data
mem_wstrb  in  4  byte strobes; a write takes effect only if mem_wstrb[0]=1
mem_rdata  out  32  read data, valid while mem_ready=1
mem_ready  out  1  one-cycle completion pulse
irq  out  1  level interrupt

Behaviour:
- Reset: one clock, synchronous, active-high; it is the only reset.
- Address map, word-aligned; addr[1:0] is ignored:
  - 0x000 CTRL (RW): bit0 START, write-1 pulse, reads 0; bit1 IRQ_EN; bit2 SIGNED.
  - 0x004 STATUS: bit0 BUSY (RO); bit1 DONE, sticky, W1C; bit2 ERR, sticky, W1C.
  - 0x008 CYCLES (RO): engine cycles used by the last run.
  - 0x100 + 4*(r*N+c): A[r][c] (RW), low DW bits.
  - 0x200 + 4*(r*N+c): B[r][c] (RW).
  - 0x300 + 4*(r*N+c): C[r][c] (RO), 32 bits.
  - Indices >= N*N and all other offsets are unmapped.
- Bus protocol:
  - Every transaction takes exactly 2 cycles. mem_valid is sampled high in cycle T; mem_ready=1 in T+1 with registered mem_rdata.
  - Write side effects commit in T+1.
  - mem_ready is never high on 2 consecutive cycles. The master may start the next request in the cycle after mem_ready.
  - mem_rdata = 0 when mem_ready=0.
  - A/B reads return DW bits zero-extended.
- Errors, each setting ERR:
  - Unmapped read returns 0xDEADBEEF. Unmapped write is ignored.
  - A write to A, B, or CTRL with START=1 while BUSY is ignored entirely, including the IRQ_EN/SIGNED bits.
  - Writes to RO registers and C are ignored but do NOT set ERR.
- Engine FSM IDLE -> RUN -> FIN -> IDLE:
  - START write in IDLE enters RUN the next cycle. BUSY=1, DONE cleared, CYCLES cleared.
  - SIGNED is latched at start.
  - RUN: one MAC per cycle with nested counters i (row), j (col), k (inner), k fastest.
    - k=0: acc = A[i][k]*B[k][j].
    - k>0: acc += A[i][k]*B[k][j].
    - At k=N-1 the final sum is written to C[i][j] in that same cycle.
  - Products are DW x DW, sign- or zero-extended per SIGNED, and accumulated to 32 bits with wrap.
  - CYCLES increments each RUN cycle. RUN lasts exactly N^3 cycles.
  - FIN (1 cycle): BUSY drops and DONE sets at the FIN->IDLE edge, i.e. DONE reads 1 starting N^3+1 cycles after the START commit.
- C reads during RUN return current contents: partially updated, no error.
- START with simultaneous W1C of DONE in the same cycle is impossible (different registers). A W1C of DONE in the same cycle the engine sets DONE leaves DONE=1 (set wins).
- irq = IRQ_EN & DONE, combinational from registers.
- Reset mid-run aborts: FSM to IDLE and all outputs and registers return to 0.
  - A, B and C are cleared to 0.
  - CTRL, STATUS and CYCLES are 0.
  - mem_ready=0, mem_rdata=0, irq=0.

Test Plan:
- N=4, A=identity, B[r][c]=r*4+c, START -> C equals B; DONE=1 exactly 65 cycles after START commit; CYCLES=64.
- SIGNED=1, all A=-128 (0x80), all B=-128 -> every C=0x00010000. Same data with SIGNED=0 -> every C = 4*128*128 = 0x00010000 (A=B=0x80 unsigned).
- SIGNED=0, all A=B=0xFF -> each C = 4*255*255 = 260100 (0x0003F804).
- Write A[0][0] and re-issue START while BUSY -> A unchanged, C unchanged, ERR=1. Write 0x4 to STATUS -> ERR=0.
- Read 0x0FC -> 0xDEADBEEF, ERR=1. Write 0x100 with mem_wstrb=4'b0010 -> A[0][0] unchanged. Check mem_ready is a single-cycle pulse one cycle after mem_valid.
- IRQ_EN=1, run to completion -> irq=1; write 0x2 to STATUS -> irq=0 next cycle. Assert rst mid-RUN -> BUSY=0, all C=0, CYCLES=0.
